// File: rtl/apb_regfile_completer_if.sv
// APB bus bundle between the team's requester and a single completer slot.
// The requester drives the master side; completers attach through the slave modport.
interface apb_regfile_completer_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
);
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [AddrWidth-1:0]   PADDR;
    logic [DataWidth-1:0]   PWDATA;
    logic [DataWidth/8-1:0] PSTRB;
    logic                   PREADY;
    logic [DataWidth-1:0]   PRDATA;
    logic                   PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_regfile_completer.sv
// APB completer fronting a byte-strobed control register bank plus a read-only
// hardware status word, with a fixed number of wait states per transfer.
module apb_regfile_completer #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned Regs       = 8,
    parameter int unsigned WaitStates = 1
) (
    input  logic                      PCLK,
    input  logic                      reset,
    apb_regfile_completer_if.slave    apb,
    input  logic [DataWidth-1:0]      HwStatus,
    output logic [Regs*DataWidth-1:0] RegOut
);

    localparam int unsigned Bytes    = DataWidth / 8;
    localparam int unsigned ByteOffW = $clog2(Bytes);
    localparam int unsigned IdxW     = $clog2(Regs);
    localparam int unsigned CntW     = 4;
    localparam logic [IdxW-1:0] StatusIdx = IdxW'(Regs - 1);

    // Elaboration-time guard on parameter legality.
    if ((DataWidth % 8) != 0 || Regs < 2 || (Regs & (Regs - 1)) != 0 ||
        WaitStates > 15 || AddrWidth <= ByteOffW + IdxW) begin : g_bad_params
        $error("apb_regfile_completer: unsupported parameter combination");
    end

    // The setup phase lasts exactly the cycle the requester presents it, so it is
    // decoded from IDLE plus the bus rather than held in its own register state.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [DataWidth-1:0]   regs_q [Regs];
    logic [DataWidth-1:0]   regs_d [Regs];

    logic                   setup_c;
    logic                   misaligned_c;
    logic                   out_of_range_c;
    logic                   ro_write_c;
    logic                   err_c;
    logic                   commit_c;
    logic [IdxW-1:0]        idx_c;
    logic                   ready_c;
    logic                   slverr_c;
    logic [DataWidth-1:0]   rdata_c;

    // Address decode and legality.
    always_comb begin
        setup_c        = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
        misaligned_c   = (apb.PADDR & AddrWidth'(Bytes - 1)) != '0;
        out_of_range_c = (apb.PADDR >> (ByteOffW + IdxW)) != '0;
        idx_c          = apb.PADDR[ByteOffW +: IdxW];
        ro_write_c     = apb.PWRITE && (idx_c == StatusIdx);
        err_c          = misaligned_c || out_of_range_c || ro_write_c;
    end

    // State register.
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (setup_c) begin
                    state_d = ACCESS;
                    cnt_d   = CntW'(WaitStates);
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (apb.PENABLE) begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus response; combinational so it tracks the requester within the cycle.
    always_comb begin
        ready_c  = (state_q == ACCESS) && apb.PSEL && (cnt_q == '0);
        slverr_c = ready_c && err_c;
        rdata_c  = '0;
        if (ready_c && !err_c && !apb.PWRITE) begin
            rdata_c = (idx_c == StatusIdx) ? HwStatus : regs_q[idx_c];
        end
    end

    assign apb.PREADY  = ready_c;
    assign apb.PSLVERR = slverr_c;
    assign apb.PRDATA  = rdata_c;

    // Byte-strobed write commit on the edge that closes the ready cycle.
    always_comb begin
        regs_d   = regs_q;
        commit_c = ready_c && apb.PWRITE && !err_c;
        if (commit_c) begin
            for (int j = 0; j < int'(Bytes); j++) begin
                if (apb.PSTRB[j]) begin
                    regs_d[idx_c][j*8 +: 8] = apb.PWDATA[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(Regs); k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(Regs); k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Flat export; the status slot carries no stored state.
    for (genvar k = 0; k < int'(Regs); k++) begin : g_regout
        if (k == int'(Regs) - 1) begin : g_status
            assign RegOut[k*DataWidth +: DataWidth] = '0;
        end else begin : g_ctrl
            assign RegOut[k*DataWidth +: DataWidth] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Self-checking bench: two completers (zero and one wait state) on a shared
// driver, compared against a word-array model of the register file.
module tb_apb_regfile_completer;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NR = 8;

    logic            PCLK = 1'b0;
    logic            reset = 1'b1;
    logic            psel = 1'b0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [AW-1:0]   paddr = '0;
    logic [DW-1:0]   pwdata = '0;
    logic [3:0]      pstrb = '0;
    logic [DW-1:0]   hw_status = '0;
    int              dsel = 1;

    logic [NR*DW-1:0] regout0, regout1;
    logic             pready, pslverr;
    logic [DW-1:0]    prdata;

    logic [31:0] mem [2][NR];
    int passed = 0;
    int total  = 0;

    always #5 PCLK = ~PCLK;

    apb_regfile_completer_if #(.DataWidth(DW), .AddrWidth(AW)) if0 ();
    apb_regfile_completer_if #(.DataWidth(DW), .AddrWidth(AW)) if1 ();

    assign if0.PSEL    = psel && (dsel == 0);
    assign if1.PSEL    = psel && (dsel == 1);
    assign if0.PENABLE = penable;
    assign if1.PENABLE = penable;
    assign if0.PWRITE  = pwrite;
    assign if1.PWRITE  = pwrite;
    assign if0.PADDR   = paddr;
    assign if1.PADDR   = paddr;
    assign if0.PWDATA  = pwdata;
    assign if1.PWDATA  = pwdata;
    assign if0.PSTRB   = pstrb;
    assign if1.PSTRB   = pstrb;

    assign pready  = (dsel == 0) ? if0.PREADY  : if1.PREADY;
    assign pslverr = (dsel == 0) ? if0.PSLVERR : if1.PSLVERR;
    assign prdata  = (dsel == 0) ? if0.PRDATA  : if1.PRDATA;

    apb_regfile_completer #(.DataWidth(DW), .AddrWidth(AW), .Regs(NR), .WaitStates(0)) dut0 (
        .PCLK(PCLK), .reset(reset), .apb(if0), .HwStatus(hw_status), .RegOut(regout0));
    apb_regfile_completer #(.DataWidth(DW), .AddrWidth(AW), .Regs(NR), .WaitStates(1)) dut1 (
        .PCLK(PCLK), .reset(reset), .apb(if1), .HwStatus(hw_status), .RegOut(regout1));

    function automatic logic [NR*DW-1:0] exp_regout(input int d);
        logic [NR*DW-1:0] r = '0;
        for (int k = 0; k < int'(NR) - 1; k++) r[k*DW +: DW] = mem[d][k];
        return r;
    endfunction

    function automatic logic [NR*DW-1:0] act_regout(input int d);
        return (d == 0) ? regout0 : regout1;
    endfunction

    function automatic int exp_cycles(input int d);
        return 2 + d;
    endfunction

    // Reference behaviour of one transfer, straight from the address rules.
    task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] erd, output logic eerr);
        int unsigned idx = addr / 4;
        eerr = (addr % 4 != 0) || (idx >= NR) || (wr && idx == NR - 1);
        erd  = '0;
        if (!eerr) begin
            if (wr) begin
                for (int j = 0; j < 4; j++)
                    if (strb[j]) mem[dsel][idx][j*8 +: 8] = data[j*8 +: 8];
            end else begin
                erd = (idx == NR - 1) ? hw_status : mem[dsel][idx];
            end
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < int'(NR); k++) mem[d][k] = '0;
    endtask

    // Drives one transfer; returns at the falling edge of the ready cycle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err,
                        output int cycles, output bit wait_nz);
        bit done = 0;
        rd = '0; err = 1'b0; wait_nz = 0;
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        cycles = 1;
        @(posedge PCLK); #1;
        penable = 1'b1;
        cycles = 2;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (pready === 1'b1) begin
                rd = prdata; err = pslverr; done = 1;
            end else begin
                if (prdata !== '0 || pslverr !== 1'b0) wait_nz = 1;
                @(posedge PCLK); #1;
                cycles++;
            end
        end
        if (!done) cycles = -1;
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 reset = 1'b0;
        clear_model();
        @(negedge PCLK);
        for (int d = 0; d < 2; d++) begin
            dsel = d;
            #1;
            total++; if (pready !== 1'b0) $display("FAIL reset_pready dut%0d: got %b want 0", d, pready); else passed++;
            total++; if (prdata !== '0) $display("FAIL reset_prdata dut%0d: got %h want 0", d, prdata); else passed++;
            total++; if (pslverr !== 1'b0) $display("FAIL reset_pslverr dut%0d: got %b want 0", d, pslverr); else passed++;
            total++; if (act_regout(d) !== '0) $display("FAIL reset_regout dut%0d: got %h want 0", d, act_regout(d)); else passed++;
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd; logic err, eerr; int cyc; bit wnz;
        dsel = 1;
        model_xfer(1, 32'h8, 32'hDEADBEEF, 4'hF, erd, eerr);
        xfer(1, 32'h8, 32'hDEADBEEF, 4'hF, rd, err, cyc, wnz);
        total++; if (cyc !== 3) $display("FAIL wr_latency: got %0d cycles want 3", cyc); else passed++;
        total++; if (wnz !== 0) $display("FAIL wr_wait_outputs: got nonzero PRDATA/PSLVERR while PREADY=0 want 0"); else passed++;
        total++; if (err !== 1'b0) $display("FAIL wr_err: got %b want 0", err); else passed++;
        total++; if (regout1[2*32 +: 32] !== 32'h0) $display("FAIL wr_early_commit: got %h want 0", regout1[2*32 +: 32]); else passed++;
        @(negedge PCLK);
        total++; if (pready !== 1'b0) $display("FAIL wr_ready_c4: got %b want 0", pready); else passed++;
        total++; if (regout1[2*32 +: 32] !== 32'hDEADBEEF) $display("FAIL wr_commit: got %h want deadbeef", regout1[2*32 +: 32]); else passed++;
        bus_idle();
        model_xfer(0, 32'h8, 32'h0, 4'h0, erd, eerr);
        xfer(0, 32'h8, 32'h0, 4'h0, rd, err, cyc, wnz);
        bus_idle();
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rd_err: got %b want 0", err); else passed++;
        total++; if (cyc !== 3) $display("FAIL rd_latency: got %0d want 3", cyc); else passed++;
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd, erd; logic err, eerr; int cyc; bit wnz;
        dsel = 1;
        model_xfer(1, 32'h8, 32'h11223344, 4'h5, erd, eerr);
        xfer(1, 32'h8, 32'h11223344, 4'h5, rd, err, cyc, wnz);
        bus_idle();
        total++; if (err !== 1'b0) $display("FAIL strb_err: got %b want 0", err); else passed++;
        total++; if (regout1[2*32 +: 32] !== 32'hDE22BE44) $display("FAIL strb_word2: got %h want de22be44", regout1[2*32 +: 32]); else passed++;
        total++; if (regout1 !== exp_regout(1)) $display("FAIL strb_regout: got %h want %h", regout1, exp_regout(1)); else passed++;
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic err, eerr; int cyc; bit wnz;
        logic [NR*DW-1:0] snap;
        dsel = 1;
        snap = exp_regout(1);
        xfer(1, 32'h1C, 32'hFFFFFFFF, 4'hF, rd, err, cyc, wnz);
        bus_idle();
        total++; if (err !== 1'b1) $display("FAIL err_status_write: got %b want 1", err); else passed++;
        total++; if (regout1 !== snap) $display("FAIL err_status_write_regs: got %h want %h", regout1, snap); else passed++;
        xfer(0, 32'h20, 32'h0, 4'h0, rd, err, cyc, wnz);
        bus_idle();
        total++; if (err !== 1'b1) $display("FAIL err_oor_read: got %b want 1", err); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL err_oor_rdata: got %h want 0", rd); else passed++;
        xfer(1, 32'h6, 32'hCAFEF00D, 4'hF, rd, err, cyc, wnz);
        bus_idle();
        total++; if (err !== 1'b1) $display("FAIL err_misaligned: got %b want 1", err); else passed++;
        total++; if (regout1 !== snap) $display("FAIL err_misaligned_regs: got %h want %h", regout1, snap); else passed++;
        hw_status = 32'hA5A5A5A5;
        model_xfer(0, 32'h1C, 32'h0, 4'h0, erd, eerr);
        xfer(0, 32'h1C, 32'h0, 4'h0, rd, err, cyc, wnz);
        bus_idle();
        total++; if (rd !== 32'hA5A5A5A5) $display("FAIL status_read: got %h want a5a5a5a5", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL status_read_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic err, eerr; int cyc; bit wnz;
        dsel = 1;
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        total++; if (pready !== 1'b0) $display("FAIL abort_wait_ready: got %b want 0", pready); else passed++;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge PCLK);
        total++; if (pready !== 1'b0) $display("FAIL abort_ready: got %b want 0", pready); else passed++;
        total++; if (regout1[31:0] !== mem[1][0]) $display("FAIL abort_word0: got %h want %h", regout1[31:0], mem[1][0]); else passed++;
        model_xfer(0, 32'h0, 32'h0, 4'h0, erd, eerr);
        xfer(0, 32'h0, 32'h0, 4'h0, rd, err, cyc, wnz);
        bus_idle();
        total++; if (cyc !== 3) $display("FAIL abort_next_latency: got %0d want 3", cyc); else passed++;
        total++; if (rd !== erd) $display("FAIL abort_readback: got %h want %h", rd, erd); else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, erd; logic err, eerr; int cyc; bit wnz;
        dsel = 1;
        model_xfer(1, 32'h10, 32'h0BADF00D, 4'hF, erd, eerr);
        xfer(1, 32'h10, 32'h0BADF00D, 4'hF, rd, err, cyc, wnz);
        bus_idle();
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        total++; if (pready !== 1'b1) $display("FAIL rst_pre_ready: got %b want 1", pready); else passed++;
        reset = 1'b1;
        #1;
        total++; if (pready !== 1'b0) $display("FAIL rst_ready_drop: got %b want 0", pready); else passed++;
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        reset = 1'b0;
        clear_model();
        @(negedge PCLK);
        total++; if (regout1 !== '0) $display("FAIL rst_regout1: got %h want 0", regout1); else passed++;
        total++; if (regout0 !== '0) $display("FAIL rst_regout0: got %h want 0", regout0); else passed++;
        for (int k = 0; k < int'(NR) - 1; k++) begin
            xfer(0, 32'(k * 4), 32'h0, 4'h0, rd, err, cyc, wnz);
            bus_idle();
            total++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL rst_readback_w%0d: got %h err %b want 0 err 0", k, rd, err); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic err, eerr; int cyc; bit wnz;
        dsel = 0;
        model_xfer(1, 32'h4, 32'hFEEDC0DE, 4'hF, erd, eerr);
        xfer(1, 32'h4, 32'hFEEDC0DE, 4'hF, rd, err, cyc, wnz);
        total++; if (cyc !== 2) $display("FAIL b2b_wr_latency: got %0d want 2", cyc); else passed++;
        model_xfer(0, 32'h4, 32'h0, 4'h0, erd, eerr);
        xfer(0, 32'h4, 32'h0, 4'h0, rd, err, cyc, wnz);
        bus_idle();
        total++; if (cyc !== 2) $display("FAIL b2b_rd_latency: got %0d want 2", cyc); else passed++;
        total++; if (rd !== 32'hFEEDC0DE) $display("FAIL b2b_rd_data: got %h want feedc0de", rd); else passed++;
        total++; if (err !== 1'b0) $display("FAIL b2b_rd_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, data; logic err, eerr; int cyc; bit wnz, wr; logic [3:0] strb;
        for (int n = 0; n < 60; n++) begin
            dsel = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            data = $urandom;
            strb = 4'($urandom);
            hw_status = $urandom;
            model_xfer(wr, addr, data, strb, erd, eerr);
            xfer(wr, addr, data, strb, rd, err, cyc, wnz);
            total++; if (cyc !== exp_cycles(dsel)) $display("FAIL rnd%0d_latency: got %0d want %0d", n, cyc, exp_cycles(dsel)); else passed++;
            total++; if (err !== eerr) $display("FAIL rnd%0d_err addr %h wr %b: got %b want %b", n, addr, wr, err, eerr); else passed++;
            if (!wr) begin
                total++; if (rd !== erd) $display("FAIL rnd%0d_rdata addr %h: got %h want %h", n, addr, rd, erd); else passed++;
            end
            bus_idle();
            total++; if (regout0 !== exp_regout(0) || regout1 !== exp_regout(1))
                $display("FAIL rnd%0d_regout: got %h / %h want %h / %h", n, regout0, regout1, exp_regout(0), exp_regout(1));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/apb_regfile_completer.md
# apb_regfile_completer

APB completer that terminates transfers issued by the team's APB requester on one `PSELx` line. It holds a bank of byte-strobed control registers plus one read-only status register, and inserts a fixed number of wait states. It flags illegal accesses on `PSLVERR`. Register contents are exported flat to downstream logic; the status word is sampled from hardware.

## Interface
- `DataWidth`, 32, data bus width; multiple of 8.
- `AddrWidth`, 32, address bus width.
- `Regs`, 8, number of words; power of two, ≥2. Words `0..Regs-2` are R/W control; word `Regs-1` is read-only status.
- `WaitStates`, 1, wait cycles per transfer (0–15).

Ports:
- `PCLK`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `PSEL`  in  1  select; one bit of the requester's `PSELx`.
- `PENABLE`  in  1  access-phase indicator.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDR`  in  AddrWidth  byte address.
- `PWDATA`  in  DataWidth  write data.
- `PSTRB`  in  DataWidth/8  byte write strobes.
- `HwStatus`  in  DataWidth  value returned when reading word `Regs-1`.
- `PREADY`  out  1  transfer completes this cycle.
- `PRDATA`  out  DataWidth  read data; valid only while `PREADY`=1.
- `PSLVERR`  out  1  error response; valid only while `PREADY`=1.
- `RegOut`  out  Regs*DataWidth  flat control words. Word k is at bits `[k*DataWidth +: DataWidth]`. The top word is driven 0.

## Operation
- Word size: B = DataWidth/8 bytes.
- Word index: `PADDR / B`.
- An access is illegal if any of the following holds; illegal accesses complete normally with `PSLVERR`=1:
  - `PADDR % B != 0` (misaligned);
  - index ≥ `Regs`;
  - it is a write to word `Regs-1`.
- FSM states:
  - IDLE → SETUP when `PSEL`=1 and `PENABLE`=0. Wait counter loads `WaitStates`.
  - SETUP → ACCESS unconditionally.
  - ACCESS, `PSEL`=1, `PENABLE`=1, counter > 0: `PREADY`=0, counter decrements, stay in ACCESS.
  - ACCESS, counter = 0: `PREADY`=1, → IDLE.
  - ACCESS with `PSEL`=0 (requester abort): → IDLE; no write and no response.
- Write commit:
  - Happens on the `PCLK` edge that ends the `PREADY`=1 cycle, and only for legal writes.
  - Byte j of the word updates only if `PSTRB[j]`=1; other bytes hold.
  - `PSTRB`=0 on a legal write completes without error and changes nothing.
- Read data:
  - Legal reads return the stored word, or `HwStatus` for word `Regs-1`, sampled in the `PREADY` cycle.
  - `PRDATA` is 0 whenever `PREADY`=0 and on error responses.
- `PADDR`, `PWRITE`, `PWDATA` and `PSTRB` are sampled in the `PREADY` cycle. The requester holds them stable from setup through completion.
- `PENABLE`=1 observed in IDLE without a preceding setup is ignored; the FSM stays in IDLE.
- Back-to-back: a new setup (`PSEL`=1, `PENABLE`=0) in the cycle after `PREADY` is accepted normally.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - `PREADY`=0, `PRDATA`=0, `PSLVERR`=0.
  - All control words = 0, so `RegOut`=0.
- Reset asserted mid-transfer: all of the above take effect immediately; a pending write is discarded.
- `PREADY`, `PRDATA` and `PSLVERR` are combinational from FSM state, counter and the current bus inputs.
- Transfer length:
  - Setup is cycle 1. `PREADY` rises in cycle 2+`WaitStates`.
  - `WaitStates`=0 gives 2 cycles, which is zero-wait APB.
- `RegOut` reflects a write in the cycle after `PREADY`.
- Counter width is 4 bits. `WaitStates` > 15 is unsupported.

## Test plan
- Reset, then idle bus: `PREADY`=0, `PRDATA`=0, `PSLVERR`=0, `RegOut`=0.
- Write 0xDEADBEEF to address 0x8 with `PSTRB`=0xF and `WaitStates`=1: `PREADY` is high in cycle 3 only. `RegOut` word 2 = 0xDEADBEEF from cycle 4. Reading 0x8 returns 0xDEADBEEF with `PSLVERR`=0.
- Partial strobe: word 2 = 0xDEADBEEF, then write 0x11223344 with `PSTRB`=0x5. Word 2 becomes 0xDE22BE44.
- Errors, each ending with `PSLVERR`=1 and no register change:
  - write to 0x1C (status word);
  - read of 0x20 (out of range), which must return `PRDATA`=0;
  - write to 0x6 (misaligned).
  - Separately, read 0x1C with `HwStatus`=0xA5A5A5A5: returns 0xA5A5A5A5 with `PSLVERR`=0.
- Abort and reset:
  - Drop `PSEL` during the wait cycle of a write to 0x0: word 0 unchanged, FSM back to IDLE.
  - Assert `reset` mid-access: `PREADY` drops immediately and all words read back as 0.
- Back-to-back, `WaitStates`=0: write 0x4, then read 0x4 in the next setup. Each transfer takes 2 cycles and the read returns the written value.
